// File: rtl/reorder_buffer.sv
// reorder_buffer: 8-entry circular ROB; allocs in order, captures CDB results by tag, retires in order.
// Ports: clk1/rst (sync, active-high), alloc_*, cdb_*, commit_*, count/full/empty; flush only with ROB_FLUSH_EN.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int REG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk1,
  input  logic              rst,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [PTR_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [REG_W-1:0]  dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              cv_q, cv_d;
  logic [REG_W-1:0]  cdest_q, cdest_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;

  logic alloc_fire;
  logic wb_fire;
  logic commit_fire;

  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign alloc_ready  = !full;
  assign alloc_tag    = tail_q;
  assign commit_valid = cv_q;
  assign commit_dest  = cdest_q;
  assign commit_data  = cdata_q;

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    dest_d  = dest_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cv_d    = 1'b0;
    cdest_d = cdest_q;
    cdata_d = cdata_q;

    alloc_fire  = alloc_valid && !full;
    wb_fire     = cdb_valid && busy_q[cdb_tag];
    commit_fire = busy_q[head_q] && ready_q[head_q];

    if (wb_fire) begin
      data_d[cdb_tag]  = cdb_data;
      ready_d[cdb_tag] = 1'b1;
    end

    // Commit reads pre-edge data and its clear wins over a same-cycle CDB.
    if (commit_fire) begin
      cv_d            = 1'b1;
      cdest_d         = dest_q[head_q];
      cdata_d         = data_q[head_q];
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
    end

    // Tail slot is never busy when alloc fires, so it cannot collide with
    // a commit or a CDB capture.
    if (alloc_fire) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      dest_d[tail_q]  = alloc_dest;
      tail_d          = tail_q + PTR_ONE;
    end

    unique case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

`ifdef ROB_FLUSH_EN
    if (flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      cv_d    = 1'b0;
      cdest_d = cdest_q;
      cdata_d = cdata_q;
    end
`endif
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      cdest_q <= '0;
      cdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      cdest_q <= cdest_d;
      cdata_q <= cdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= dest_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
